// File: rtl/seq_multiplier16.sv
// Sequential unsigned shift-add multiplier: DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH
// over DATA_WIDTH iteration cycles, with a start/busy/done handshake.
module seq_multiplier16 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   acc_shift;
  logic [DATA_WIDTH-1:0] mplier_shift;

  // acc never exceeds DATA_WIDTH bits between iterations, so the add keeps its carry in bit DATA_WIDTH.
  always_comb begin
    sum          = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
    acc_shift    = {1'b0, sum[DATA_WIDTH:1]};
    mplier_shift = {sum[0], mplier_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      IDLE, DONE: begin
        done_d = 1'b0;
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_shift;
        mplier_d = mplier_shift;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          hi_d    = acc_shift[DATA_WIDTH-1:0];
          lo_d    = mplier_shift;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign product_hi = hi_q;
  assign product_lo = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_multiplier16.sv
// Self-checking bench for seq_multiplier16: behavioural reference model with a
// product scoreboard queue, per-cycle output comparison and directed scenarios.
module tb_seq_multiplier16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic [15:0] product_hi, product_lo;
  logic        busy, done;

  seq_multiplier16 #(.DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .product_hi (product_hi),
    .product_lo (product_lo),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_prod = '0;
  logic [31:0] ds_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: product from '*', timing from a countdown of 16 iterations.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_left = 0;
      m_done = 1'b0;
      m_prod = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (exp_q.size() > 0) m_prod = exp_q.pop_front();
          else m_prod = 32'hDEAD_BEEF;
        end
      end else if (start) begin
        exp_q.push_back(32'(a) * 32'(b));
        m_busy = 1'b1;
        m_left = 16;
      end
    end
  end

  // Downstream enable-gated result register.
  always @(posedge clk or posedge rst) begin
    if (rst) ds_q <= '0;
    else if (done) ds_q <= {product_hi, product_lo};
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("product", {product_hi, product_lo}, m_prod);
    if (done) done_cnt++;
  end

  task automatic op(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
  endtask

  task automatic expect_dones(input string tag, input int base, input int n);
    repeat (30) @(negedge clk);
    check(tag, 32'(done_cnt - base), 32'(n));
  endtask

  int base;
  int t0;
  int n;
  int times[3];

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", {product_hi, product_lo}, 32'd0);
    rst = 1'b0;

    base = done_cnt;
    op(16'd3, 16'd5);
    expect_dones("t1_dones", base, 1);
    check("t1_prod", {product_hi, product_lo}, 32'h0000_000F);
    check("t1_downstream", ds_q, 32'h0000_000F);

    base = done_cnt;
    op(16'hFFFF, 16'hFFFF);
    expect_dones("t2_dones", base, 1);
    check("t2_prod", {product_hi, product_lo}, 32'hFFFE_0001);

    base = done_cnt;
    op(16'h1234, 16'h0000);
    repeat (8) @(negedge clk);
    check("t3_hold", {product_hi, product_lo}, 32'hFFFE_0001);
    expect_dones("t3_dones", base, 1);
    check("t3_prod", {product_hi, product_lo}, 32'h0);

    base = done_cnt;
    op(16'h0002, 16'h0003);
    repeat (5) @(negedge clk);
    a = 16'h00FF; b = 16'h00FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_dones("t4_dones", base, 1);
    check("t4_prod", {product_hi, product_lo}, 32'h0000_0006);

    base = done_cnt;
    op(16'h1111, 16'h0011);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_prod", {product_hi, product_lo}, 32'd0);
    @(negedge clk);
    a = 16'd5; b = 16'd7; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    expect_dones("t5_dones", base, 1);
    check("t5_prod", {product_hi, product_lo}, 32'h0000_0023);

    @(negedge clk);
    t0 = cyc;
    n = 0;
    a = 16'h0010; b = 16'h0010; start = 1'b1;
    for (int i = 0; i < 80 && n < 3; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        times[n] = cyc;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("t6_dones", 32'(n), 32'd3);
    if (n == 3) begin
      check("t6_latency", 32'(times[0] - t0), 32'd17);
      check("t6_gap1", 32'(times[1] - times[0]), 32'd17);
      check("t6_gap2", 32'(times[2] - times[1]), 32'd17);
    end
    check("t6_prod", {product_hi, product_lo}, 32'h0000_0100);
    base = done_cnt;
    expect_dones("t6_no_more", base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
